// File: rtl/audio_pkg.sv
// Shared types and constants for the speaker sample FIFO: the state encodings
// for the CPU-side and speaker-side handshake FSMs, and the sample width.
package audio_pkg;

  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    C_IDLE = 2'h0,
    C_PUSH = 2'h1,
    C_RESP = 2'h2
  } cpu_state_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'h0,
    S_REQ  = 2'h1,
    S_POP  = 2'h2,
    S_WAIT = 2'h3
  } spk_state_e;

endpackage

// File: rtl/speaker_sample_fifo_if.sv
// Handshake bundle between the CPU port logic, the sample FIFO and the speaker
// controller. The FIFO is the slave; the CPU/speaker side is the master.
interface speaker_sample_fifo_if;
  import audio_pkg::*;

  logic                cpu_command;
  logic                cpu_response;
  logic [SAMPLE_W-1:0] cpu_sample;
  logic                speaker_command;
  logic                speaker_response;
  logic [SAMPLE_W-1:0] speaker_sample;

  modport slave (
    input  cpu_command,
    input  cpu_sample,
    input  speaker_response,
    output cpu_response,
    output speaker_command,
    output speaker_sample
  );

  modport master (
    output cpu_command,
    output cpu_sample,
    output speaker_response,
    input  cpu_response,
    input  speaker_command,
    input  speaker_sample
  );

endinterface

// File: rtl/sample_fifo_mem.sv
// Sample storage for the speaker FIFO: DEPTH x SAMPLE_W register array with a
// synchronous write port and an asynchronous read port.
module sample_fifo_mem
  import audio_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];

  // Write port; contents carry no reset because stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/speaker_sample_fifo.sv
// Speaker sample FIFO: accepts CPU samples over a four-phase handshake and
// offers them one at a time to the speaker controller over a second four-phase
// handshake. An entry stays counted until the speaker acknowledges it.
module speaker_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clock_25m,
  input  logic                 reset_25m_n,
  speaker_sample_fifo_if.slave bus,
  output logic [ADDR_W:0]      fifo_count,
  output logic                 fifo_empty,
  output logic                 fifo_full
);

  if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : g_param_check
    $error("DEPTH must be a power of 2, at least 2, and equal to 2**ADDR_W");
  end

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  cpu_state_e          c_state_q, c_state_d;
  spk_state_e          s_state_q, s_state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                cpu_response_q;
  logic                speaker_command_q;
  logic [SAMPLE_W-1:0] speaker_sample_q, speaker_sample_d;
  logic [SAMPLE_W-1:0] mem_rdata;
  logic                push, pop, empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign push  = (c_state_q == C_PUSH);
  assign pop   = (s_state_q == S_POP);

  sample_fifo_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk_i  (clock_25m),
    .we_i   (push),
    .waddr_i(wptr_q),
    .wdata_i(bus.cpu_sample),
    .raddr_i(rptr_q),
    .rdata_o(mem_rdata)
  );

  // CPU side: wait for a command with room available, write once, then hold
  // the response until the CPU withdraws its command.
  always_comb begin
    c_state_d = c_state_q;
    case (c_state_q)
      C_IDLE:  if (bus.cpu_command && !full) c_state_d = C_PUSH;
      C_PUSH:  c_state_d = C_RESP;
      C_RESP:  if (!bus.cpu_command) c_state_d = C_IDLE;
      default: c_state_d = C_IDLE;
    endcase
  end

  // Speaker side: latch the head entry, request until acknowledged, retire the
  // entry, then wait for the acknowledge to drop before offering the next one.
  always_comb begin
    s_state_d        = s_state_q;
    speaker_sample_d = speaker_sample_q;
    case (s_state_q)
      S_IDLE: begin
        if (!empty) begin
          speaker_sample_d = mem_rdata;
          s_state_d        = S_REQ;
        end
      end
      S_REQ:   if (bus.speaker_response) s_state_d = S_POP;
      S_POP:   s_state_d = S_WAIT;
      S_WAIT:  if (!bus.speaker_response) s_state_d = S_IDLE;
      default: s_state_d = S_IDLE;
    endcase
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop cancel out.
  always_comb begin
    wptr_d  = push ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d  = pop  ? (rptr_q + PTR_ONE) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State, pointers and registered outputs; outputs decode the next state so
  // they line up exactly with C_RESP / S_REQ without any input-to-output path.
  always_ff @(posedge clock_25m or negedge reset_25m_n) begin
    if (!reset_25m_n) begin
      c_state_q         <= C_IDLE;
      s_state_q         <= S_IDLE;
      wptr_q            <= '0;
      rptr_q            <= '0;
      count_q           <= '0;
      cpu_response_q    <= 1'b0;
      speaker_command_q <= 1'b0;
      speaker_sample_q  <= '0;
    end else begin
      c_state_q         <= c_state_d;
      s_state_q         <= s_state_d;
      wptr_q            <= wptr_d;
      rptr_q            <= rptr_d;
      count_q           <= count_d;
      cpu_response_q    <= (c_state_d == C_RESP);
      speaker_command_q <= (s_state_d == S_REQ);
      speaker_sample_q  <= speaker_sample_d;
    end
  end

  assign bus.cpu_response    = cpu_response_q;
  assign bus.speaker_command = speaker_command_q;
  assign bus.speaker_sample  = speaker_sample_q;
  assign fifo_count          = count_q;
  assign fifo_empty          = empty;
  assign fifo_full           = full;

  a_no_push_when_full: assert property (
    @(posedge clock_25m) disable iff (!reset_25m_n) !(push && full));
  a_no_pop_when_empty: assert property (
    @(posedge clock_25m) disable iff (!reset_25m_n) !(pop && empty));

endmodule

// File: tb/tb_speaker_sample_fifo.sv
// Testbench for speaker_sample_fifo: directed CPU writes, a configurable
// speaker-controller responder, and a transaction-level model of the FIFO.
module tb_speaker_sample_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;

  speaker_sample_fifo_if bus ();

  speaker_sample_fifo #(
    .DEPTH (16),
    .ADDR_W(4)
  ) dut (
    .clock_25m  (clk),
    .reset_25m_n(rst_n),
    .bus        (bus),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;

  // speaker-controller responder controls
  logic manual      = 1'b0;
  logic manual_resp = 1'b0;
  logic auto_resp   = 1'b0;
  bit   ack_enable  = 1'b0;
  bit   rand_mode   = 1'b0;
  int   ack_delay   = 0;
  int   ack_hold    = 0;

  assign bus.speaker_response = manual ? manual_resp : auto_resp;

  // model state
  logic [31:0] mq[$];
  logic [31:0] got[$];
  int          mc      = 0;
  int          max_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted write enters the queue (and the count) in
  // the cycle cpu_response rises; each offer must present the queue head; an
  // acknowledged offer leaves the queue when the command drops and leaves the
  // count one cycle later.
  initial begin : monitor
    logic        p_resp, p_cmd, p_sresp, pop_pend;
    logic [31:0] p_sample;
    p_resp = 0; p_cmd = 0; p_sresp = 0; pop_pend = 0; p_sample = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mq.delete();
        mc = 0; pop_pend = 0; p_resp = 0; p_cmd = 0; p_sresp = 0; p_sample = '0;
        check("rst_count", fifo_count, 0);
        check("rst_spk_cmd", bus.speaker_command, 0);
        check("rst_cpu_resp", bus.cpu_response, 0);
        check("rst_spk_sample", bus.speaker_sample, 0);
      end else begin
        if (pop_pend) begin
          mc--;
          pop_pend = 0;
        end
        if (bus.cpu_response && !p_resp) begin
          mq.push_back(bus.cpu_sample);
          mc++;
        end
        if (bus.speaker_command && !p_cmd) begin
          check("cmd_rise_resp_low", p_sresp, 0);
          got.push_back(bus.speaker_sample);
          if (mq.size() == 0) check("offer_without_entry", 1, 0);
          else check("offer_sample", bus.speaker_sample, mq[0]);
        end
        if (p_cmd) check("sample_hold", bus.speaker_sample, p_sample);
        if (!bus.speaker_command && p_cmd) begin
          if (mq.size() > 0) void'(mq.pop_front());
          pop_pend = 1;
        end
        check("count", fifo_count, mc);
        check("empty", fifo_empty, (mc == 0));
        check("full", fifo_full, (mc == 16));
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        p_resp   = bus.cpu_response;
        p_cmd    = bus.speaker_command;
        p_sresp  = bus.speaker_response;
        p_sample = bus.speaker_sample;
      end
    end
  end

  // Speaker controller: acknowledge an offer after a delay, keep the
  // acknowledge until the command drops plus a hold time.
  initial begin : responder
    int rs, wcnt, hcnt, cur;
    rs = 0; wcnt = 0; hcnt = 0; cur = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || manual) begin
        auto_resp = 1'b0;
        rs = 0;
      end else begin
        case (rs)
          0: if (bus.speaker_command && ack_enable) begin
            cur  = rand_mode ? int'($urandom_range(0, 10)) : ack_delay;
            wcnt = 0;
            if (cur == 0) begin
              auto_resp = 1'b1; hcnt = 0; rs = 2;
            end else rs = 1;
          end
          1: begin
            wcnt++;
            if (wcnt >= cur) begin
              auto_resp = 1'b1; hcnt = 0; rs = 2;
            end
          end
          default: if (!bus.speaker_command) begin
            if (hcnt >= ack_hold) begin
              auto_resp = 1'b0; rs = 0;
            end else hcnt++;
          end
        endcase
      end
    end
  end

  task automatic cpu_write(input logic [31:0] s);
    int n;
    @(negedge clk);
    bus.cpu_sample  = s;
    bus.cpu_command = 1'b1;
    n = 0;
    while (!bus.cpu_response && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("cpu_write_accepted", bus.cpu_response, 1);
    bus.cpu_command = 1'b0;
    n = 0;
    while (bus.cpu_response && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cpu_resp_release", bus.cpu_response, 0);
  endtask

  task automatic wait_drain(input int n_expect);
    int n;
    n = 0;
    while (!(got.size() >= n_expect && fifo_count == 0 && !bus.speaker_command) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", (got.size() >= n_expect && fifo_count == 0), 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int n;
    bus.cpu_command = 1'b0;
    bus.cpu_sample  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_count", fifo_count, 0);
    check("reset_empty", fifo_empty, 1);
    check("reset_full", fifo_full, 0);
    check("reset_spk_cmd", bus.speaker_command, 0);
    check("reset_cpu_resp", bus.cpu_response, 0);
    check("reset_spk_sample", bus.speaker_sample, 0);
    rst_n = 1'b1;
    ack_enable = 1; ack_delay = 3; ack_hold = 0;
    repeat (2) @(negedge clk);

    // single write, latency and 3-cycle acknowledge
    got.delete();
    @(negedge clk);
    bus.cpu_sample = 32'h12345678; bus.cpu_command = 1'b1;
    @(negedge clk);
    check("t1_resp_c1", bus.cpu_response, 0);
    check("t1_count_c1", fifo_count, 0);
    @(negedge clk);
    check("t1_resp_c2", bus.cpu_response, 1);
    check("t1_count_c2", fifo_count, 1);
    bus.cpu_command = 1'b0;
    @(negedge clk);
    check("t1_spk_cmd", bus.speaker_command, 1);
    check("t1_spk_sample", bus.speaker_sample, 32'h12345678);
    repeat (3) begin
      @(negedge clk);
      check("t1_spk_cmd_held", bus.speaker_command, 1);
    end
    @(negedge clk);
    check("t1_spk_cmd_fall", bus.speaker_command, 0);
    check("t1_count_before_pop", fifo_count, 1);
    @(negedge clk);
    check("t1_count_after_pop", fifo_count, 0);
    check("t1_empty_after_pop", fifo_empty, 1);
    wait_drain(1);
    check("t1_got_n", got.size(), 1);
    check("t1_got0", got[0], 32'h12345678);
    repeat (4) @(negedge clk);

    // fill to full, 17th write stalls until one acknowledge
    ack_enable = 0; got.delete();
    for (int i = 1; i <= 16; i++) cpu_write(32'(i));
    @(negedge clk);
    check("t2_full", fifo_full, 1);
    check("t2_count", fifo_count, 16);
    check("t2_not_empty", fifo_empty, 0);
    bus.cpu_sample = 32'h11; bus.cpu_command = 1'b1;
    repeat (6) @(negedge clk);
    check("t2_stall_resp", bus.cpu_response, 0);
    check("t2_stall_count", fifo_count, 16);
    ack_delay = 0; ack_enable = 1;
    n = 0;
    while (!bus.cpu_response && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t2_17th_accepted", bus.cpu_response, 1);
    bus.cpu_command = 1'b0;
    wait_drain(17);
    check("t2_got_n", got.size(), 17);
    for (int i = 0; i < 17; i++) check("t2_order", got[i], 32'(i + 1));
    repeat (4) @(negedge clk);

    // simultaneous push and pop with five entries held
    ack_enable = 0; got.delete();
    for (int i = 0; i < 5; i++) cpu_write(32'h30 + 32'(i));
    repeat (3) @(negedge clk);
    check("t3_count_pre", fifo_count, 5);
    check("t3_spk_cmd_pre", bus.speaker_command, 1);
    manual = 1; manual_resp = 0;
    @(negedge clk);
    bus.cpu_sample = 32'h35; bus.cpu_command = 1'b1; manual_resp = 1;
    @(negedge clk);
    check("t3_count_mid", fifo_count, 5);
    check("t3_spk_cmd_dropped", bus.speaker_command, 0);
    @(negedge clk);
    check("t3_count_after", fifo_count, 5);
    check("t3_cpu_resp", bus.cpu_response, 1);
    bus.cpu_command = 1'b0; manual_resp = 0;
    repeat (4) @(negedge clk);
    check("t3_count_settled", fifo_count, 5);
    check("t3_next_cmd", bus.speaker_command, 1);
    check("t3_next_sample", bus.speaker_sample, 32'h31);
    manual = 0; ack_delay = 1; ack_enable = 1;
    wait_drain(6);
    check("t3_got_n", got.size(), 6);
    for (int i = 0; i < 6; i++) check("t3_order", got[i], 32'h30 + 32'(i));
    repeat (4) @(negedge clk);

    // 40-sample stream with random acknowledge delays
    got.delete(); rand_mode = 1; ack_enable = 1; max_cnt = 0;
    for (int i = 0; i < 40; i++) cpu_write(32'hA000_0000 + 32'(i));
    wait_drain(40);
    rand_mode = 0;
    check("t4_got_n", got.size(), 40);
    for (int i = 0; i < 40; i++) check("t4_order", got[i], 32'hA000_0000 + 32'(i));
    check("t4_max_count_le_depth", (max_cnt <= 16), 1);
    repeat (4) @(negedge clk);

    // reset in the middle of an offer with three entries held
    ack_enable = 0; got.delete();
    for (int i = 0; i < 3; i++) cpu_write(32'h50 + 32'(i));
    repeat (3) @(negedge clk);
    check("t5_cmd_before_reset", bus.speaker_command, 1);
    check("t5_count_before_reset", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_cpu_resp", bus.cpu_response, 0);
    check("t5_rst_spk_cmd", bus.speaker_command, 0);
    check("t5_rst_spk_sample", bus.speaker_sample, 0);
    check("t5_rst_count", fifo_count, 0);
    check("t5_rst_empty", fifo_empty, 1);
    check("t5_rst_full", fifo_full, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got.delete(); ack_delay = 2; ack_enable = 1;
    cpu_write(32'hCAFE0000);
    wait_drain(1);
    check("t5_got_n", got.size(), 1);
    check("t5_first_after_reset", got[0], 32'hCAFE0000);
    repeat (4) @(negedge clk);

    // acknowledge held for 5 cycles after the command drops
    ack_enable = 0; got.delete(); ack_delay = 1; ack_hold = 5;
    cpu_write(32'h60);
    cpu_write(32'h61);
    @(negedge clk);
    ack_enable = 1;
    n = 0;
    while (bus.speaker_command && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_first_cmd_fall", bus.speaker_command, 0);
    n = 0;
    while (bus.speaker_response && n < 50) begin
      check("t6_no_cmd_during_hold", bus.speaker_command, 0);
      @(negedge clk);
      n++;
    end
    check("t6_hold_seen", (n >= 5), 1);
    n = 0;
    while (!bus.speaker_command && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_second_cmd", bus.speaker_command, 1);
    check("t6_second_sample", bus.speaker_sample, 32'h61);
    ack_hold = 0;
    wait_drain(2);
    check("t6_got_n", got.size(), 2);
    check("t6_got1", got[1], 32'h61);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/speaker_sample_fifo.md
Name: speaker_sample_fifo

Overview:
- Buffers CPU-written audio samples and feeds them one at a time to the speaker controller over its four-phase speaker_command/speaker_response handshake.
- Sits between the CPU I/O port logic and the speaker controller, in the 25 MHz domain.
- Lets the CPU write a burst of samples without blocking for each 8.1 kHz sample period.
- The CPU side uses the same four-phase handshake style.

Parameters:
- DEPTH, 16, number of sample entries; must be a power of 2 and at least 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clock_25m  in  1  system clock
- reset_25m_n  in  1  reset, asynchronous assert, active-low
- cpu_command  in  1  CPU requests a sample write (four-phase)
- cpu_response  out  1  write accepted; held high until cpu_command falls
- cpu_sample  in  32  sample from CPU; sampled while cpu_command=1
- speaker_command  out  1  request to speaker controller (four-phase)
- speaker_response  in  1  speaker controller acknowledge
- speaker_sample  out  32  sample presented to speaker controller; stable while speaker_command=1
- fifo_count  out  ADDR_W+1  number of entries held, 0..DEPTH
- fifo_empty  out  1  fifo_count==0
- fifo_full  out  1  fifo_count==DEPTH

Behaviour:
- Reset (reset_25m_n=0, asynchronous):
  - cpu_response=0, speaker_command=0, speaker_sample=0.
  - Pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0.
  - Both FSMs go to IDLE.
  - Storage contents are don't-care; buffered samples are discarded.
- Reset mid-handshake: the same applies; the speaker controller sees command drop and returns to idle by its own rules.
- All outputs are registered; there is no combinational path from any input to any output.
- CPU FSM:
  - C_IDLE: if cpu_command=1 and fifo_full=0, go to C_PUSH. If full, stay in C_IDLE; the CPU stalls with no response.
  - C_PUSH: write cpu_sample to mem[wptr]; wptr+1 (wraps mod DEPTH); go to C_RESP.
  - C_RESP: cpu_response=1. Stay while cpu_command=1; go to C_IDLE when cpu_command=0.
  - cpu_response is high exactly while the FSM is in C_RESP.
  - Timing: command sampled high at edge N gives push at N+1 and cpu_response=1 from N+2.
- Speaker FSM:
  - S_IDLE: if fifo_empty=0, load speaker_sample from mem[rptr] and go to S_REQ.
  - S_REQ: speaker_command=1. When speaker_response=1, go to S_POP.
  - S_POP: speaker_command=0; rptr+1 (wraps); go to S_WAIT.
  - S_WAIT: when speaker_response=0, go to S_IDLE.
  - The entry stays in the FIFO until it is acknowledged, so fifo_count includes the sample currently being offered.
  - speaker_sample holds its last value after S_POP; it does not return to 0.
- Count rules:
  - Push (C_PUSH) adds 1; pop (S_POP) subtracts 1.
  - Push and pop in the same cycle leave the count unchanged and both pointers advance.
  - Never push when full; never pop when empty. The FSM guards guarantee this, and assertions check it.
- Latency: a push into an empty FIFO at cycle N gives fifo_count=1 at N+1, speaker_command=1 at N+2, and speaker_sample valid at N+2.
- Wrap-around: DEPTH+1 consecutive pushes interleaved with pops must return samples in exact write order.
- Full case: with DEPTH entries held and the CPU waiting, the first S_POP frees a slot. C_IDLE sees fifo_full=0 on the next cycle and proceeds.
- Empty case: the speaker FSM idles with speaker_command=0. The speaker controller's own decay handles silence.

Decomposition:
- Shared package audio_pkg holds:
  - the CPU FSM state encodings (C_IDLE=2'h0, C_PUSH=2'h1, C_RESP=2'h2);
  - the speaker FSM state encodings (S_IDLE=2'h0, S_REQ=2'h1, S_POP=2'h2, S_WAIT=2'h3);
  - the SAMPLE_W=32 constant.
- One natural sub-module, sample_fifo_mem: a DEPTH x 32 register array with a synchronous write port and an asynchronous read port indexed by rptr.

Test Plan:
- Reset, then one CPU write of 32'h12345678 -> cpu_response rises 2 cycles after the command is seen. speaker_command rises with speaker_sample=32'h12345678. Model acks after 3 cycles -> fifo_count goes 1->0 and speaker_command falls the cycle after the ack.
- CPU writes 16 samples 32'h1..32'h10 with the speaker model never acking -> fifo_full=1, fifo_count=16. A 17th cpu_command gets no cpu_response. One ack -> the 17th write completes; the speaker receives 1..17 in order.
- Push and pop in the same cycle with fifo_count=5 -> fifo_count stays 5; both pointers advance.
- 40 samples streamed through with random ack delays of 0-10 cycles -> output order matches input across pointer wrap; count never exceeds 16 or underflows.
- Assert reset_25m_n low while speaker_command=1 and 3 entries are held -> all outputs are 0 immediately and fifo_count=0. After release, a new write of 32'hCAFE0000 is delivered first.
- Speaker model holds speaker_response=1 for 5 cycles after ack -> the FIFO stays in S_WAIT and offers no new command until the response drops.
